// File: rtl/alu_arbiter.sv
// Arbitrates NREQ valid/ready requesters onto one single-cycle 32-bit ALU with a one-entry response buffer.
// Define ALU_ARB_RR_EN for round-robin grant; the default build uses fixed lowest-index priority.

module alu_arbiter_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result
);
  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    result = 32'hBEEF_DEAD;
    unique case (op)
      4'd0:    result = a + b;
      4'd1:    result = a - b;
      4'd2:    result = a & b;
      4'd3:    result = a | b;
      4'd4:    result = a ^ b;
      4'd5:    result = a << shamt;
      4'd6:    result = a >> shamt;
      4'd7:    result = $unsigned($signed(a) >>> shamt);
      4'd8:    result = {31'd0, $signed(a) < $signed(b)};
      4'd9:    result = {31'd0, a < b};
      default: result = 32'hBEEF_DEAD;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*4-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_result,
  output logic                 rsp_zero,
  output logic [IDW-1:0]       rsp_id
);
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     result_q, result_d;
  logic            zero_q, zero_d;
  logic [IDW-1:0]  id_q, id_d;

  logic [NREQ-1:0] grant_c;
  logic [IDW-1:0]  grant_id_c;
  logic            grant_any_c;
  logic            can_accept_c;
  logic            accept_c;
  logic [31:0]     alu_a_c;
  logic [31:0]     alu_b_c;
  logic [3:0]      alu_op_c;
  logic [31:0]     alu_res_c;

`ifdef ALU_ARB_RR_EN
  logic [IDW-1:0]  last_id_q, last_id_d;

  // Round-robin: search starts just after the last winner and wraps.
  always_comb begin
    int unsigned idx;
    grant_id_c  = '0;
    grant_any_c = 1'b0;
    idx         = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_id_q) + k) % NREQ;
      if (!grant_any_c && req_valid[IDW'(idx)]) begin
        grant_any_c = 1'b1;
        grant_id_c  = IDW'(idx);
      end
    end
  end

  assign last_id_d = accept_c ? grant_id_c : last_id_q;
`else
  // Fixed priority: lowest asserted index wins.
  always_comb begin
    grant_id_c  = '0;
    grant_any_c = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_any_c && req_valid[i]) begin
        grant_any_c = 1'b1;
        grant_id_c  = IDW'(i);
      end
    end
  end
`endif

  always_comb begin
    grant_c             = '0;
    grant_c[grant_id_c] = grant_any_c;
  end

  assign rsp_valid    = (state_q == S_FULL);
  assign can_accept_c = !rsp_valid || rsp_ready;
  assign req_ready    = grant_c & {NREQ{can_accept_c & rst_n}};
  assign accept_c     = |req_ready;

  // Steer the winner's operands to the shared ALU.
  always_comb begin
    alu_a_c  = '0;
    alu_b_c  = '0;
    alu_op_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        alu_a_c  = req_a[32*i +: 32];
        alu_b_c  = req_b[32*i +: 32];
        alu_op_c = req_op[4*i +: 4];
      end
    end
  end

  alu_arbiter_alu u_alu (
    .a      (alu_a_c),
    .b      (alu_b_c),
    .op     (alu_op_c),
    .result (alu_res_c)
  );

  // Response buffer: an accept always loads; otherwise a consumed entry empties.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    id_d     = id_q;
    if (accept_c) begin
      state_d  = S_FULL;
      result_d = alu_res_c;
      zero_d   = (alu_res_c == 32'd0);
      id_d     = grant_id_c;
    end else if (state_q == S_FULL && rsp_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      result_q  <= '0;
      zero_q    <= 1'b0;
      id_q      <= '0;
`ifdef ALU_ARB_RR_EN
      last_id_q <= IDW'(NREQ - 1);
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      id_q      <= id_d;
`ifdef ALU_ARB_RR_EN
      last_id_q <= last_id_d;
`endif
    end
  end

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_id     = id_q;
endmodule
